// File: rtl/wbgpio_sched.sv
// Timed GPIO output scheduler: queues (delay, mask, value) commands and replays
// each as a single-beat Wishbone write of {mask, value} after its delay expires.
`timescale 1ns/1ps
module wbgpio_sched #(
    parameter int LGFIFO = 3,
    parameter int DW     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DW-1:0]     i_cmd_delay,
    input  logic [15:0]       i_cmd_mask,
    input  logic [15:0]       i_cmd_value,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [31:0]       o_wb_data,
    output logic [3:0]        o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    output logic              o_busy,
    output logic              o_empty,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_err,
    output logic [1:0]        o_state
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int EW    = DW + 32;
    localparam logic [LGFIFO:0] FULL_FILL = (LGFIFO+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUS, S_ACK} state_t;

    logic [EW-1:0]     fifo_mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   fill;
    logic [EW-1:0]     head;
    logic              full, push, pop;

    state_t            state, state_n;
    logic [DW-1:0]     cnt, cnt_n;
    logic              cyc_n, stb_n, load, err_set;

    // Command handshake: a command transfers on any cycle where valid && ready;
    // ready is low while full or while reset is asserted.
    assign full        = (fill == FULL_FILL);
    assign o_cmd_ready = !i_reset && !full;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign head        = fifo_mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {i_cmd_delay, i_cmd_mask, i_cmd_value};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_data <= '0;
            o_err     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            o_wb_cyc <= cyc_n;
            o_wb_stb <= stb_n;
            if (load)
                o_wb_data <= head[31:0];
            if (err_set)
                o_err <= 1'b1;
        end
    end

    // Bus errors win over acks; an errored command is dropped, never retried.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cyc_n   = o_wb_cyc;
        stb_n   = o_wb_stb;
        pop     = 1'b0;
        load    = 1'b0;
        err_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!o_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    cnt_n   = head[EW-1:32];
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    state_n = S_BUS;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_BUS: begin
                if (i_wb_err) begin
                    cyc_n   = 1'b0;
                    stb_n   = 1'b0;
                    err_set = 1'b1;
                    state_n = S_IDLE;
                end else if (!i_wb_stall) begin
                    stb_n = 1'b0;
                    if (i_wb_ack) begin
                        cyc_n   = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (i_wb_err) begin
                    cyc_n   = 1'b0;
                    err_set = 1'b1;
                    state_n = S_IDLE;
                end else if (i_wb_ack) begin
                    cyc_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign o_wb_we  = 1'b1;
    assign o_wb_sel = 4'hf;
    assign o_busy   = (state != S_IDLE);
    assign o_empty  = (fill == '0);
    assign o_fill   = fill;
    assign o_state  = state;

endmodule

// File: tb/tb_wbgpio_sched.sv
// Bench for wbgpio_sched: table rows, hand sequences and random traffic against
// a Wishbone GPIO slave model and a cycle-arithmetic schedule model.
`timescale 1ns/1ps
module tb_wbgpio_sched;
    localparam int LGFIFO = 3;
    localparam int DW     = 16;

    logic              clk = 1'b0;
    logic              i_reset, i_cmd_valid, o_cmd_ready;
    logic [DW-1:0]     i_cmd_delay;
    logic [15:0]       i_cmd_mask, i_cmd_value;
    logic              o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0]       o_wb_data;
    logic [3:0]        o_wb_sel;
    logic              i_wb_stall, i_wb_ack, i_wb_err;
    logic              o_busy, o_empty, o_err;
    logic [LGFIFO:0]   o_fill;
    logic [1:0]        o_state;

    wbgpio_sched #(.LGFIFO(LGFIFO), .DW(DW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_delay(i_cmd_delay), .i_cmd_mask(i_cmd_mask), .i_cmd_value(i_cmd_value),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_busy(o_busy), .o_empty(o_empty), .o_fill(o_fill), .o_err(o_err),
        .o_state(o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard state ----------------
    typedef struct {
        int            acc;
        logic [DW-1:0] d;
        logic [15:0]   m;
        logic [15:0]   v;
    } cmd_t;
    typedef struct {
        int          rise;
        int          acc;
        logic [31:0] data;
    } wr_t;

    logic [31:0] exp_q[$];
    cmd_t        cmd_q[$];
    wr_t         got_q[$];
    int          stall_plan [64];
    bit          err_plan [64];
    int          lat;

    task automatic clear_plans();
        for (int i = 0; i < 64; i++) begin
            stall_plan[i] = 0;
            err_plan[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- GPIO slave model (acts on negedges) ----------------
    int          widx, pend, stall_left, rise_c;
    bit          cur_err;
    logic [15:0] gpio;
    logic        p_stb, p_stall, p_ack, p_err, p_rst;
    logic [31:0] p_data;
    wr_t         w_tmp;

    always @(negedge clk) begin
        if (i_reset) begin
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
            widx = 0; pend = 0; stall_left = 0; gpio = '0;
            got_q.delete();
            p_stb = 1'b0; p_stall = 1'b0; p_ack = 1'b0; p_err = 1'b0; p_rst = 1'b1;
        end else begin
            if (!p_rst) begin
                if (p_stb && p_stall) begin
                    check("stall_hold_stb", o_wb_stb, 1);
                    check("stall_hold_data", o_wb_data, p_data);
                end
                if (p_stb && !p_stall)
                    check("stb_drop_after_accept", o_wb_stb, 0);
                if (p_ack || p_err)
                    check("cyc_drop_after_resp", {o_wb_cyc, o_wb_stb}, 0);
                if (o_wb_stb)
                    check("stb_inside_cyc", o_wb_cyc, 1);
            end
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
            if (o_wb_cyc && o_wb_stb) begin
                if (!p_stb) begin
                    rise_c     = cyc_cnt;
                    stall_left = stall_plan[widx % 64];
                end
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    w_tmp.rise = rise_c;
                    w_tmp.acc  = cyc_cnt;
                    w_tmp.data = o_wb_data;
                    got_q.push_back(w_tmp);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write actual=%0h required=none", o_wb_data);
                    end else begin
                        check("write_data", o_wb_data, exp_q.pop_front());
                    end
                    cur_err = err_plan[widx % 64];
                    if (!cur_err)
                        gpio = (gpio & ~o_wb_data[31:16]) | (o_wb_data[15:0] & o_wb_data[31:16]);
                    widx++;
                    if (lat == 0) begin
                        if (cur_err) i_wb_err = 1'b1;
                        else         i_wb_ack = 1'b1;
                    end else begin
                        pend = lat;
                    end
                end
            end else if (o_wb_cyc && pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (cur_err) i_wb_err = 1'b1;
                    else         i_wb_ack = 1'b1;
                end
            end
            p_stb = o_wb_stb; p_stall = i_wb_stall; p_ack = i_wb_ack;
            p_err = i_wb_err; p_data = o_wb_data; p_rst = 1'b0;
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic push_cmd(input logic [DW-1:0] d, input logic [15:0] m, input logic [15:0] v);
        int   guard = 0;
        cmd_t c;
        i_cmd_valid = 1'b1;
        i_cmd_delay = d;
        i_cmd_mask  = m;
        i_cmd_value = v;
        while (!o_cmd_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!o_cmd_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=ready_low required=ready_high");
        end else begin
            c.acc = cyc_cnt; c.d = d; c.m = m; c.v = v;
            cmd_q.push_back(c);
            exp_q.push_back({m, v});
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (!(got_q.size() >= n && !o_busy && o_empty) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!(got_q.size() >= n && !o_busy && o_empty)) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=%0d writes required=%0d", got_q.size(), n);
        end
    endtask

    // Schedule model: each command starts when both it has arrived and the
    // previous one has finished; strobe, accept and finish follow by arithmetic.
    task automatic run_model(input string tag);
        int          prev_done = 0;
        int          pop_c, rise, acc, done;
        logic [15:0] g = '0;
        bit          any_err = 1'b0;
        check({tag, "_nwrites"}, got_q.size(), cmd_q.size());
        for (int i = 0; i < cmd_q.size(); i++) begin
            pop_c = (cmd_q[i].acc + 1 > prev_done) ? cmd_q[i].acc + 1 : prev_done;
            rise  = pop_c + 2 + int'(cmd_q[i].d);
            acc   = rise + stall_plan[i];
            done  = acc + 1 + lat;
            prev_done = done;
            if (i < got_q.size()) begin
                check({tag, "_rise"}, got_q[i].rise, rise);
                check({tag, "_accept"}, got_q[i].acc, acc);
                check({tag, "_data"}, got_q[i].data, {cmd_q[i].m, cmd_q[i].v});
            end
            if (err_plan[i]) any_err = 1'b1;
            else g = (g & ~cmd_q[i].m) | (cmd_q[i].v & cmd_q[i].m);
        end
        check({tag, "_gpio"}, gpio, g);
        check({tag, "_err"}, o_err, any_err);
        check({tag, "_fill"}, o_fill, 0);
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [15:0]   m;
        logic [15:0]   v;
        int            stall;
        int            lat;
        bit            err;
        int            exp_off;
        logic [31:0]   exp_data;
        bit            exp_err;
        logic [15:0]   exp_gpio;
    } vec_t;
    vec_t vecs [6];

    initial begin
        vecs[0] = '{16'd0,     16'h0001, 16'h0001, 0, 0, 1'b0, 3,     32'h00010001, 1'b0, 16'h0001};
        vecs[1] = '{16'd5,     16'h0001, 16'h0001, 0, 0, 1'b0, 8,     32'h00010001, 1'b0, 16'h0001};
        vecs[2] = '{16'd0,     16'hFFFF, 16'hA5A5, 3, 2, 1'b0, 3,     32'hFFFFA5A5, 1'b0, 16'hA5A5};
        vecs[3] = '{16'd2,     16'h00F0, 16'h1234, 1, 1, 1'b1, 5,     32'h00F01234, 1'b1, 16'h0000};
        vecs[4] = '{16'd1,     16'h0F00, 16'hFFFF, 0, 1, 1'b0, 4,     32'h0F00FFFF, 1'b0, 16'h0F00};
        vecs[5] = '{16'hFFFF,  16'h8000, 16'h8000, 0, 0, 1'b0, 65538, 32'h80008000, 1'b0, 16'h8000};

        i_reset = 1'b1; i_cmd_valid = 1'b0;
        i_cmd_delay = '0; i_cmd_mask = '0; i_cmd_value = '0;
        lat = 0;
        clear_plans();

        // reset values
        repeat (2) @(negedge clk);
        check("ready_in_reset", o_cmd_ready, 0);
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_cyc_stb", {o_wb_cyc, o_wb_stb}, 0);
        check("rst_data", o_wb_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_empty", o_empty, 1);
        check("rst_fill", o_fill, 0);
        check("rst_err", o_err, 0);
        check("rst_ready", o_cmd_ready, 1);
        check("we_sel", {o_wb_we, o_wb_sel}, 5'h1f);

        // table rows, one command each
        for (int r = 0; r < 6; r++) begin
            do_reset();
            clear_plans();
            stall_plan[0] = vecs[r].stall;
            err_plan[0]   = vecs[r].err;
            lat           = vecs[r].lat;
            push_cmd(vecs[r].d, vecs[r].m, vecs[r].v);
            wait_done(1, vecs[r].exp_off + 40);
            check("row_nwrites", got_q.size(), 1);
            if (got_q.size() >= 1) begin
                check("row_rise_offset", got_q[0].rise - cmd_q[0].acc, vecs[r].exp_off);
                check("row_stb_len", got_q[0].acc - got_q[0].rise, vecs[r].stall);
                check("row_data", got_q[0].data, vecs[r].exp_data);
            end
            check("row_err", o_err, vecs[r].exp_err);
            check("row_gpio", gpio, vecs[r].exp_gpio);
            check("row_fill", o_fill, 0);
        end

        // set then clear bit 0
        do_reset(); clear_plans(); lat = 0;
        push_cmd(16'd5, 16'h0001, 16'h0001);
        push_cmd(16'd0, 16'h0001, 16'h0000);
        wait_done(2, 200);
        run_model("setclr");
        check("setclr_bit0", gpio[0], 0);

        // fill to depth behind a stalling slave
        do_reset(); clear_plans(); lat = 0;
        for (int i = 0; i < 10; i++) stall_plan[i] = 20;
        for (int i = 0; i < 9; i++) push_cmd(DW'(i % 3), 16'(16'h0011 << i), 16'($urandom));
        check("full_fill", o_fill, 8);
        check("full_ready", o_cmd_ready, 0);
        push_cmd(16'd1, 16'hF000, 16'h5000);
        wait_done(10, 2000);
        run_model("fill");

        // random traffic, zero-latency then 2-cycle acks
        for (int b = 0; b < 2; b++) begin
            do_reset(); clear_plans(); lat = (b == 0) ? 0 : 2;
            for (int i = 0; i < 20; i++) begin
                stall_plan[i] = $urandom_range(0, 4);
                err_plan[i]   = ($urandom_range(0, 7) == 0);
            end
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                push_cmd(DW'($urandom_range(0, 6)), 16'($urandom), 16'($urandom));
            end
            wait_done(20, 5000);
            run_model(b == 0 ? "rand_lat0" : "rand_lat2");
        end

        // reset while waiting with three commands queued
        do_reset(); clear_plans(); lat = 0;
        push_cmd(16'd30, 16'h0001, 16'h0001);
        for (int i = 0; i < 3; i++) push_cmd(16'd0, 16'h00FF, 16'h00AA);
        check("rstwait_fill", o_fill, 3);
        check("rstwait_state", o_state, 1);
        i_reset = 1'b1;
        exp_q.delete();
        cmd_q.delete();
        @(negedge clk);
        check("rstwait_cyc", o_wb_cyc, 0);
        check("rstwait_fill0", o_fill, 0);
        check("rstwait_busy", o_busy, 0);
        check("rstwait_ready", o_cmd_ready, 0);
        i_reset = 1'b0;
        repeat (60) @(negedge clk);
        check("rstwait_nowrite", got_q.size(), 0);
        check("rstwait_idle", {o_wb_cyc, o_busy}, 0);

        // error on the second of three
        do_reset(); clear_plans(); lat = 1;
        err_plan[1] = 1'b1;
        push_cmd(16'd0, 16'h0003, 16'h0001);
        push_cmd(16'd1, 16'h0004, 16'h0004);
        push_cmd(16'd2, 16'h0008, 16'h0008);
        wait_done(3, 300);
        run_model("err2");
        repeat (10) @(negedge clk);
        check("err_sticky", o_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
